// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Groups the control, product-input and result-output signals of the
//   product accumulator into one bundle.
//   master : the side that drives start/len/abort, the products and acc_ready
//            (testbench or upstream controller).
//   slave  : the accumulator itself.
//   Signals:
//     start, len, abort            - job control (master -> slave)
//     prod_valid, prod_data        - product stream (master -> slave)
//     prod_ready                   - product accepted this cycle (slave -> master)
//     acc_valid, acc_data          - final sum (slave -> master)
//     acc_ready                    - downstream takes the sum (master -> slave)
//     overflow, busy               - status (slave -> master)
interface product_accumulator_if #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             prod_valid;
    logic [31:0]      prod_data;
    logic             prod_ready;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_data;
    logic             acc_ready;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, abort, prod_valid, prod_data, acc_ready,
        input  prod_ready, acc_valid, acc_data, overflow, busy
    );

    modport slave (
        input  start, len, abort, prod_valid, prod_data, acc_ready,
        output prod_ready, acc_valid, acc_data, overflow, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a programmed number of 32-bit unsigned products into an ACC_W-bit
//   accumulator (dot product / MAC result). Products arrive on a valid/ready
//   handshake at up to one per clock; the finished sum is offered on a second
//   valid/ready handshake and held until taken.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - product_accumulator_if.slave (control, product stream, result)
//   Every output is a register, so there is no combinational path from any
//   input to any output.
module product_accumulator #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    product_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] COUNT_ONE = LEN_W'(1'b1);

    // Sum of the accumulator and a zero-extended product; the top bit is the
    // carry out of bit ACC_W-1.
    function automatic logic [ACC_W:0] add_with_carry(
        input logic [ACC_W-1:0] a,
        input logic [31:0]      b
    );
        add_with_carry = {1'b0, a} + (ACC_W+1)'(b);
    endfunction

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [LEN_W-1:0] count_r;
    logic             overflow_r;
    logic             prod_ready_r;
    logic             acc_valid_r;
    logic             busy_r;

    logic [ACC_W:0]   sum_s;
    logic             xfer_s;

    // Next accumulator value and product handshake; prod_ready_r is high only in ACC.
    always_comb begin
        sum_s  = add_with_carry(acc_r, bus.prod_data);
        xfer_s = bus.prod_valid & prod_ready_r;
    end

    // Control FSM with registered handshake/status outputs; abort wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            acc_r        <= '0;
            count_r      <= '0;
            overflow_r   <= 1'b0;
            prod_ready_r <= 1'b0;
            acc_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else if (bus.abort) begin
            // Partial sum is left in place; the next start clears it.
            state_r      <= ST_IDLE;
            prod_ready_r <= 1'b0;
            acc_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_r      <= '0;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bus.len != '0) begin
                            count_r      <= bus.len;
                            state_r      <= ST_ACC;
                            prod_ready_r <= 1'b1;
                            acc_valid_r  <= 1'b0;
                        end else begin
                            // Empty job: offer a zero result straight away.
                            state_r      <= ST_HOLD;
                            prod_ready_r <= 1'b0;
                            acc_valid_r  <= 1'b1;
                        end
                    end else begin
                        prod_ready_r <= 1'b0;
                        acc_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (xfer_s) begin
                        acc_r      <= sum_s[ACC_W-1:0];
                        overflow_r <= overflow_r | sum_s[ACC_W];
                        count_r    <= count_r - COUNT_ONE;
                        if (count_r == COUNT_ONE) begin
                            state_r      <= ST_HOLD;
                            prod_ready_r <= 1'b0;
                            acc_valid_r  <= 1'b1;
                        end else begin
                            state_r      <= ST_ACC;
                        end
                    end else begin
                        state_r <= ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (bus.acc_ready) begin
                        // start in this same cycle is deliberately not seen.
                        state_r     <= ST_IDLE;
                        acc_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    prod_ready_r <= 1'b0;
                    acc_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_r;
    assign bus.acc_valid  = acc_valid_r;
    assign bus.acc_data   = acc_r;
    assign bus.overflow   = overflow_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Self-checking bench for product_accumulator: a 40-bit instance for the
//   main scenarios and a 32-bit instance for wrap/overflow and async reset.
//   Expected sums come from plain 64-bit arithmetic over the product list.
module tb_product_accumulator;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    logic [31:0] prod_q[$];

    product_accumulator_if #(.ACC_W(40), .LEN_W(8)) bus ();
    product_accumulator_if #(.ACC_W(32), .LEN_W(8)) n32 ();

    product_accumulator #(.ACC_W(40), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    product_accumulator #(.ACC_W(32), .LEN_W(8)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (n32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job of n products from prod_q on the 40-bit instance and checks
    // handshakes, the result, its stability while held and the return to idle.
    task automatic do_job(input int n, input bit gaps, input int hold_cycles,
                          input bit hammer, input string name);
        logic [63:0] sum;
        logic [39:0] exp_acc;
        logic        exp_ovf;
        int idx;
        int budget;
        sum = 64'd0;
        for (int i = 0; i < n; i++) sum += 64'(prod_q[i]);
        exp_acc = sum[39:0];
        exp_ovf = (sum[63:40] != 24'd0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        idx = 0;
        budget = 0;
        while (idx < n && budget < 4 * n + 20) begin
            @(negedge clk);
            budget++;
            bus.start = hammer;
            if (hammer) bus.len = 8'($urandom_range(0, 255));
            checks++;
            if (bus.prod_ready !== 1'b1 || bus.busy !== 1'b1 || bus.acc_valid !== 1'b0) begin
                $display("FAIL %s acc_phase: prod_ready=%b busy=%b acc_valid=%b required 1 1 0",
                         name, bus.prod_ready, bus.busy, bus.acc_valid);
                errors++;
            end
            bus.prod_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.prod_data  = bus.prod_valid ? prod_q[idx] : $urandom;
            if (bus.prod_valid) idx++;
        end
        checks++;
        if (idx < n) begin
            $display("FAIL %s timeout: fed=%0d required %0d", name, idx, n);
            errors++;
        end

        @(negedge clk);
        bus.start      = hammer;
        bus.prod_valid = 1'b1;          // offered in HOLD, must not be consumed
        bus.prod_data  = $urandom;
        checks++;
        if (bus.acc_valid !== 1'b1 || bus.prod_ready !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL %s result_flags: acc_valid=%b prod_ready=%b busy=%b required 1 0 1",
                     name, bus.acc_valid, bus.prod_ready, bus.busy);
            errors++;
        end
        checks++;
        if (bus.acc_data !== exp_acc || bus.overflow !== exp_ovf) begin
            $display("FAIL %s result: acc_data=%h overflow=%b required %h %b",
                     name, bus.acc_data, bus.overflow, exp_acc, exp_ovf);
            errors++;
        end
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            bus.prod_data = $urandom;
            checks++;
            if (bus.acc_valid !== 1'b1 || bus.prod_ready !== 1'b0 || bus.acc_data !== exp_acc) begin
                $display("FAIL %s hold: acc_valid=%b prod_ready=%b acc_data=%h required 1 0 %h",
                         name, bus.acc_valid, bus.prod_ready, bus.acc_data, exp_acc);
                errors++;
            end
        end
        bus.acc_ready = 1'b1;           // start may still be high: must be ignored
        @(negedge clk);
        bus.acc_ready  = 1'b0;
        bus.start      = 1'b0;
        bus.prod_valid = 1'b0;
        checks++;
        if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.acc_data !== exp_acc || bus.overflow !== exp_ovf) begin
            $display("FAIL %s release: acc_valid=%b busy=%b acc_data=%h overflow=%b required 0 0 %h %b",
                     name, bus.acc_valid, bus.busy, bus.acc_data, bus.overflow, exp_acc, exp_ovf);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.prod_ready, bus.busy, bus.acc_valid, bus.overflow} !== 4'b0000 ||
            bus.acc_data !== 40'd0) begin
            $display("FAIL reset: ready/busy/valid/ovf=%b acc_data=%h required 0000 0",
                     {bus.prod_ready, bus.busy, bus.acc_valid, bus.overflow}, bus.acc_data);
            errors++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        prod_q = {32'd1, 32'd2, 32'd3, 32'd4};
        do_job(4, 1'b0, 0, 1'b0, "basic");
    endtask

    task automatic test_max_len();
        prod_q = {};
        for (int i = 0; i < 255; i++) prod_q.push_back(32'hFFFE0001);
        do_job(255, 1'b0, 1, 1'b0, "max_len");
    endtask

    task automatic test_gaps_hold();
        prod_q = {};
        for (int i = 0; i < 3; i++) prod_q.push_back($urandom);
        do_job(3, 1'b1, 5, 1'b0, "gaps_hold");
    endtask

    task automatic test_zero_len();
        prod_q = {};
        bus.prod_valid = 1'b1;
        do_job(0, 1'b0, 2, 1'b0, "zero_len");
    endtask

    task automatic test_abort();
        prod_q = {};
        for (int i = 0; i < 4; i++) prod_q.push_back($urandom);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd4;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.prod_valid = 1'b1;
        bus.prod_data  = prod_q[0];
        @(negedge clk);
        bus.prod_data  = prod_q[1];
        @(negedge clk);
        bus.abort = 1'b1;               // beats both the transfer and the start
        bus.start = 1'b1;
        bus.len   = 8'd3;
        bus.prod_data = prod_q[2];
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.prod_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0 || bus.prod_ready !== 1'b0) begin
                $display("FAIL abort_acc: acc_valid=%b busy=%b prod_ready=%b required 0 0 0",
                         bus.acc_valid, bus.busy, bus.prod_ready);
                errors++;
            end
            @(negedge clk);
        end
        prod_q = {32'd7};
        do_job(1, 1'b0, 0, 1'b0, "after_abort");

        // abort while a result is held
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL abort_hold: acc_valid=%b busy=%b required 0 0", bus.acc_valid, bus.busy);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 16);
            prod_q = {};
            for (int i = 0; i < n; i++) prod_q.push_back($urandom);
            do_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'(j % 2), "random_job");
        end
    endtask

    task automatic test_narrow_and_async_reset();
        logic [63:0] sum;
        sum = 64'h0_FFFE0001 + 64'h0_FFFE0001;
        @(negedge clk);
        n32.start = 1'b1;
        n32.len   = 8'd2;
        @(negedge clk);
        n32.start      = 1'b0;
        n32.prod_valid = 1'b1;
        n32.prod_data  = 32'hFFFE0001;
        @(negedge clk);
        @(negedge clk);
        n32.prod_valid = 1'b0;
        checks++;
        if (n32.acc_valid !== 1'b1 || n32.acc_data !== sum[31:0] || n32.overflow !== (sum[63:32] != 32'd0)) begin
            $display("FAIL narrow_wrap: acc_valid=%b acc_data=%h overflow=%b required 1 %h %b",
                     n32.acc_valid, n32.acc_data, n32.overflow, sum[31:0], sum[63:32] != 32'd0);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (n32.acc_valid !== 1'b0 || n32.acc_data !== 32'd0 || n32.overflow !== 1'b0 ||
            n32.busy !== 1'b0) begin
            $display("FAIL async_reset: acc_valid=%b acc_data=%h overflow=%b busy=%b required 0 0 0 0",
                     n32.acc_valid, n32.acc_data, n32.overflow, n32.busy);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.len = 8'd0; bus.abort = 1'b0;
        bus.prod_valid = 1'b0; bus.prod_data = 32'd0; bus.acc_ready = 1'b0;
        n32.start = 1'b0; n32.len = 8'd0; n32.abort = 1'b0;
        n32.prod_valid = 1'b0; n32.prod_data = 32'd0; n32.acc_ready = 1'b0;
        test_reset();
        test_basic();
        test_max_len();
        test_gaps_hold();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_narrow_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
